// File: rtl/tbm_responder_pkg.sv
// tbm_bus_defs: shared TBM bus widths, beat geometry and block-tracker state encodings.
package tbm_bus_defs;
  localparam int MDATA_WIDTH = 256;
  localparam int ADDRESS_WIDTH = 32;
  localparam int BEATS_PER_BLOCK = 128;
  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_BLK = 2'd1,
    RD_BLK = 2'd2
  } blk_state_t;
endpackage

// File: rtl/tbm_responder_if.sv
// tbm_responder_if: TBM beat request lines plus per-block completion/error pulses.
interface tbm_responder_if;
  import tbm_bus_defs::*;
  logic chip_select;
  logic write_enable;
  logic [ADDRESS_WIDTH-1:0] maddress;
  logic blk_wr_done;
  logic blk_rd_done;
  logic addr_err;
  logic seq_err;
  modport master (
    output chip_select, write_enable, maddress,
    input blk_wr_done, blk_rd_done, addr_err, seq_err
  );
  modport slave (
    input chip_select, write_enable, maddress,
    output blk_wr_done, blk_rd_done, addr_err, seq_err
  );
endinterface

// File: rtl/tbm_responder_block_tracker.sv
// tbm_block_tracker: counts contiguous same-direction beats into blocks and registers done/error pulses.
module tbm_block_tracker
  import tbm_bus_defs::*;
#(
  parameter int ADDRESS_WIDTH = tbm_bus_defs::ADDRESS_WIDTH,
  parameter int BEATS_PER_BLOCK = tbm_bus_defs::BEATS_PER_BLOCK
) (
  input  logic clock_fpga,
  input  logic reset,
  input  logic chip_select,
  input  logic write_enable,
  input  logic addr_valid,
  input  logic [ADDRESS_WIDTH-1:0] maddress,
  output logic blk_wr_done,
  output logic blk_rd_done,
  output logic addr_err,
  output logic seq_err
);
  blk_state_t state, state_n;
  logic [7:0] beat_cnt, cnt_n, cnt_inc;
  logic [ADDRESS_WIDTH-1:0] next_addr, next_n;
  logic wr_n, rd_n, ae_n, se_n, same_dir;
  assign cnt_inc = beat_cnt + 8'd1;
  assign same_dir = (state == WR_BLK && write_enable) || (state == RD_BLK && !write_enable);
  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      state <= IDLE;
      beat_cnt <= '0;
      next_addr <= '0;
      blk_wr_done <= 1'b0;
      blk_rd_done <= 1'b0;
      addr_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state <= state_n;
      beat_cnt <= cnt_n;
      next_addr <= next_n;
      blk_wr_done <= wr_n;
      blk_rd_done <= rd_n;
      addr_err <= ae_n;
      seq_err <= se_n;
    end
  end
  // Invalid beats leave the block untouched; a broken block restarts at the offending beat.
  always_comb begin
    state_n = state;
    cnt_n = beat_cnt;
    next_n = next_addr;
    wr_n = 1'b0;
    rd_n = 1'b0;
    ae_n = 1'b0;
    se_n = 1'b0;
    if (chip_select && !addr_valid) begin
      ae_n = 1'b1;
    end else if (chip_select) begin
      if (same_dir && maddress == next_addr) begin
        if (cnt_inc == 8'(BEATS_PER_BLOCK)) begin
          state_n = IDLE;
          cnt_n = '0;
          wr_n = write_enable;
          rd_n = !write_enable;
        end else begin
          cnt_n = cnt_inc;
          next_n = next_addr + ADDRESS_WIDTH'(BEAT_BYTES);
        end
      end else begin
        se_n = state != IDLE;
        state_n = write_enable ? WR_BLK : RD_BLK;
        cnt_n = 8'd1;
        next_n = maddress + ADDRESS_WIDTH'(BEAT_BYTES);
      end
    end
  end
endmodule

// File: rtl/tbm_responder.sv
// tbm_responder: TBM backing store with combinational reads and block tracking.
// TBM_STATS_EN adds saturating block/error counters.
module tbm_responder
  import tbm_bus_defs::*;
#(
  parameter int MDATA_WIDTH = tbm_bus_defs::MDATA_WIDTH,
  parameter int ADDRESS_WIDTH = tbm_bus_defs::ADDRESS_WIDTH,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int DEPTH_WORDS = 512,
  parameter int BEATS_PER_BLOCK = tbm_bus_defs::BEATS_PER_BLOCK
) (
  input  logic clock_fpga,
  input  logic reset,
  tbm_responder_if.slave bus,
  inout  wire [MDATA_WIDTH-1:0] mdata_inout
`ifdef TBM_STATS_EN
  ,
  output logic [15:0] wr_blk_count,
  output logic [15:0] rd_blk_count,
  output logic [15:0] err_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  logic [MDATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [ADDRESS_WIDTH-1:0] offset, word;
  logic [IDX_W-1:0] idx;
  logic valid;
  assign offset = bus.maddress - ADDRESS_WIDTH'(BASE_ADDR);
  assign word = offset >> BEAT_SHIFT;
  assign idx = word[IDX_W-1:0];
  assign valid = bus.maddress[BEAT_SHIFT-1:0] == '0 && word < ADDRESS_WIDTH'(DEPTH_WORDS);
  always_ff @(posedge clock_fpga) begin
    if (bus.chip_select && bus.write_enable && valid) mem[idx] <= mdata_inout;
  end
  // Invalid reads still drive the bus (with zero) so the initiator never samples a floating value.
  assign mdata_inout = (bus.chip_select && !bus.write_enable) ? (valid ? mem[idx] : '0) : 'z;
  tbm_block_tracker #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .BEATS_PER_BLOCK(BEATS_PER_BLOCK)
  ) u_tracker (
    .clock_fpga(clock_fpga),
    .reset(reset),
    .chip_select(bus.chip_select),
    .write_enable(bus.write_enable),
    .addr_valid(valid),
    .maddress(bus.maddress),
    .blk_wr_done(bus.blk_wr_done),
    .blk_rd_done(bus.blk_rd_done),
    .addr_err(bus.addr_err),
    .seq_err(bus.seq_err)
  );
`ifdef TBM_STATS_EN
  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      wr_blk_count <= '0;
      rd_blk_count <= '0;
      err_count <= '0;
    end else begin
      if (bus.blk_wr_done && wr_blk_count != 16'hFFFF) wr_blk_count <= wr_blk_count + 16'd1;
      if (bus.blk_rd_done && rd_blk_count != 16'hFFFF) rd_blk_count <= rd_blk_count + 16'd1;
      if ((bus.addr_err || bus.seq_err) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tbm_responder.sv
// tb_tbm_responder: directed vectors and block sequences for tbm_responder.
module tb_tbm_responder;
  logic clock_fpga = 1'b0;
  logic reset;
  logic drv;
  logic [255:0] wdata;
  wire [255:0] mdata_inout;
  int checks = 0;
  int errors = 0;
  int exp_wr = 0, exp_rd = 0, exp_err = 0;
  tbm_responder_if bus();
  assign mdata_inout = drv ? wdata : 'z;
`ifdef TBM_STATS_EN
  logic [15:0] wr_blk_count, rd_blk_count, err_count;
`endif
  tbm_responder dut (
    .clock_fpga(clock_fpga),
    .reset(reset),
    .bus(bus.slave),
    .mdata_inout(mdata_inout)
`ifdef TBM_STATS_EN
    ,
    .wr_blk_count(wr_blk_count),
    .rd_blk_count(rd_blk_count),
    .err_count(err_count)
`endif
  );
  always #5 clock_fpga = ~clock_fpga;
  typedef struct {
    logic cs;
    logic we;
    logic [31:0] a;
    logic [255:0] d;
    logic chk;
    logic [255:0] er;
    logic [3:0] ep;
  } vec_t;
  vec_t tv[15];
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  // Called at a negedge: applies one cycle, checks read data before the edge and pulses after it.
  task automatic beat(input logic c, input logic w, input logic [31:0] a, input logic [255:0] d,
                      input logic chk, input logic [255:0] er, input logic [3:0] ep, input string name);
    bus.chip_select = c;
    bus.write_enable = w;
    bus.maddress = a;
    wdata = d;
    drv = c & w;
    #1;
    if (chk) check({name, " rdata"}, mdata_inout, er);
    @(posedge clock_fpga);
    @(negedge clock_fpga);
    check({name, " pulses"}, 256'({bus.blk_wr_done, bus.blk_rd_done, bus.addr_err, bus.seq_err}), 256'(ep));
    exp_wr += int'(ep[3]);
    exp_rd += int'(ep[2]);
    exp_err += int'(ep[1] | ep[0]);
  endtask
  task automatic idle(input string name);
    beat(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 256'h0, 4'b0000, name);
  endtask
  initial begin
    reset = 1'b1;
    drv = 1'b0;
    wdata = '0;
    bus.chip_select = 1'b0;
    bus.write_enable = 1'b0;
    bus.maddress = '0;
    tv[0] = '{1'b1, 1'b1, 32'h4000, 256'hAA, 1'b0, 256'h0, 4'b0010};
    tv[1] = '{1'b1, 1'b1, 32'h0010, 256'hBB, 1'b0, 256'h0, 4'b0010};
    tv[2] = '{1'b1, 1'b0, 32'h4000, 256'h0, 1'b1, 256'h0, 4'b0010};
    tv[3] = '{1'b1, 1'b0, 32'h0010, 256'h0, 1'b1, 256'h0, 4'b0010};
    tv[4] = '{1'b1, 1'b0, 32'h0020, 256'h0, 1'b1, 256'd1, 4'b0000};
    tv[5] = '{1'b1, 1'b0, 32'h0040, 256'h0, 1'b1, 256'd2, 4'b0000};
    tv[6] = '{1'b0, 1'b0, 32'h0000, 256'h0, 1'b0, 256'h0, 4'b0000};
    tv[7] = '{1'b1, 1'b0, 32'h0060, 256'h0, 1'b1, 256'd3, 4'b0000};
    tv[8] = '{1'b1, 1'b1, 32'h0080, 256'h55, 1'b0, 256'h0, 4'b0001};
    tv[9] = '{1'b1, 1'b0, 32'h0080, 256'h0, 1'b1, 256'h55, 4'b0001};
    tv[10] = '{1'b1, 1'b0, 32'h00A0, 256'h0, 1'b1, 256'd5, 4'b0000};
    tv[11] = '{1'b1, 1'b0, 32'h0100, 256'h0, 1'b1, 256'd8, 4'b0001};
    tv[12] = '{1'b1, 1'b0, 32'h4000, 256'h0, 1'b1, 256'h0, 4'b0010};
    tv[13] = '{1'b1, 1'b0, 32'h0120, 256'h0, 1'b1, 256'd9, 4'b0000};
    tv[14] = '{1'b0, 1'b1, 32'h0000, 256'h0, 1'b0, 256'h0, 4'b0000};
    repeat (2) @(posedge clock_fpga);
    @(negedge clock_fpga);
    check("reset pulses", 256'({bus.blk_wr_done, bus.blk_rd_done, bus.addr_err, bus.seq_err}), 256'h0);
    reset = 1'b0;
    idle("post-reset idle");
    for (int i = 0; i < 128; i++)
      beat(1'b1, 1'b1, 32'(i * 32), 256'(i), 1'b0, 256'h0, (i == 127) ? 4'b1000 : 4'b0000, "wr block");
    idle("after wr block");
    for (int i = 0; i < 128; i++) begin
      beat(1'b1, 1'b0, 32'(i * 32), 256'h0, 1'b1, 256'(i), (i == 127) ? 4'b0100 : 4'b0000, "rd block");
      if (i % 32 == 31) idle("rd gap");
    end
    beat(1'b1, 1'b1, 32'h1000, 256'h100, 1'b0, 256'h0, 4'b0000, "skip first");
    beat(1'b1, 1'b1, 32'h1040, 256'h101, 1'b0, 256'h0, 4'b0001, "skip break");
    for (int k = 0; k < 127; k++)
      beat(1'b1, 1'b1, 32'h1060 + 32'(k * 32), 256'(1000 + k), 1'b0, 256'h0,
           (k == 126) ? 4'b1000 : 4'b0000, "restart block");
    for (int v = 0; v < 15; v++)
      beat(tv[v].cs, tv[v].we, tv[v].a, tv[v].d, tv[v].chk, tv[v].er, tv[v].ep, $sformatf("vec%0d", v));
    for (int i = 0; i < 60; i++)
      beat(1'b1, 1'b1, 32'h2000 + 32'(i * 32), 256'(500 + i), 1'b0, 256'h0,
           (i == 0) ? 4'b0001 : 4'b0000, "partial block");
    reset = 1'b1;
    idle("mid-block reset");
    reset = 1'b0;
    idle("after mid-block reset");
    for (int i = 0; i < 128; i++)
      beat(1'b1, 1'b1, 32'h3000 + 32'(i * 32), 256'(2000 + i), 1'b0, 256'h0,
           (i == 127) ? 4'b1000 : 4'b0000, "fresh block");
    for (int i = 0; i < 4; i++)
      beat(1'b1, 1'b0, 32'h2000 + 32'(i * 32), 256'h0, 1'b1, 256'(500 + i), 4'b0000, "retained");
    beat(1'b1, 1'b0, 32'h3FE0, 256'h0, 1'b1, 256'd2127, 4'b0001, "last word");
    idle("tail");
`ifdef TBM_STATS_EN
    check("wr_blk_count", 256'(wr_blk_count), 256'(exp_wr));
    check("rd_blk_count", 256'(rd_blk_count), 256'(exp_rd));
    check("err_count", 256'(err_count), 256'(exp_err));
    reset = 1'b1;
    idle("stats reset");
    reset = 1'b0;
    check("wr_blk_count reset", 256'(wr_blk_count), 256'h0);
    check("rd_blk_count reset", 256'(rd_blk_count), 256'h0);
    check("err_count reset", 256'(err_count), 256'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
